// File: rtl/alu_32.sv
// alu_32 - registered 32-bit integer ALU for the MIPS execute stage.
//
// Operations: AND, OR, NOR, ADD (signed), ADDU (unsigned), SUB (signed)
// and SLT (signed). The operands and control are sampled on every rising
// edge. The result and the flags appear one cycle later. There is no
// handshake, and a new operation is accepted every cycle.
//
// Ports:
//   clk                 - clock; all state changes on the rising edge
//   rst                 - synchronous active-high reset (priority over ops)
//   input_a, input_b    - WORD_SIZE operands
//   control             - 4-bit operation select
//   result              - registered operation result
//   zero                - registered; 1 when the registered result is all zeros
//   cout                - registered adder carry out of the MSB
//   err_overflow        - registered overflow flag (advisory, no trap)
//   err_invalid_control - registered; 1 when control is not a known opcode
//
// Optional build macro ALU_STICKY_ERR_EN: when it is defined, err_overflow and
// err_invalid_control stay at 1 once set, until rst clears them.
module alu_32 #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] input_a,
    input  logic [WORD_SIZE-1:0] input_b,
    input  logic [3:0]           control,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero,
    output logic                 cout,
    output logic                 err_overflow,
    output logic                 err_invalid_control
);

    localparam logic [3:0] CONTROL_AND          = 4'b0000;
    localparam logic [3:0] CONTROL_OR           = 4'b0001;
    localparam logic [3:0] CONTROL_ADD          = 4'b0010;
    localparam logic [3:0] CONTROL_ADD_UNSIGNED = 4'b0011;
    localparam logic [3:0] CONTROL_SUB          = 4'b0110;
    localparam logic [3:0] CONTROL_SLT          = 4'b0111;
    localparam logic [3:0] CONTROL_NOR          = 4'b1100;

    localparam int MSB = WORD_SIZE - 1;

    // One shared adder. Subtraction and SLT use a + ~b + 1.
    logic                 use_sub;
    logic [WORD_SIZE-1:0] adder_b;
    logic [WORD_SIZE:0]   adder_sum;
    logic                 add_ovf;
    logic                 sub_ovf;

    always_comb begin
        use_sub   = (control == CONTROL_SUB) || (control == CONTROL_SLT);
        adder_b   = use_sub ? ~input_b : input_b;
        adder_sum = {1'b0, input_a} + {1'b0, adder_b}
                    + {{WORD_SIZE{1'b0}}, use_sub};
        add_ovf   = (input_a[MSB] == input_b[MSB]) &&
                    (adder_sum[MSB] != input_a[MSB]);
        sub_ovf   = (input_a[MSB] != input_b[MSB]) &&
                    (adder_sum[MSB] != input_a[MSB]);
    end

    logic [WORD_SIZE-1:0] next_result;
    logic                 next_cout;
    logic                 next_ovf;
    logic                 next_invalid;

    always_comb begin
        next_result  = '0;
        next_cout    = 1'b0;
        next_ovf     = 1'b0;
        next_invalid = 1'b0;
        case (control)
            CONTROL_AND: next_result = input_a & input_b;
            CONTROL_OR:  next_result = input_a | input_b;
            CONTROL_NOR: next_result = ~(input_a | input_b);
            CONTROL_ADD: begin
                next_result = adder_sum[MSB:0];
                next_cout   = adder_sum[WORD_SIZE];
                next_ovf    = add_ovf;
            end
            CONTROL_ADD_UNSIGNED: begin
                next_result = adder_sum[MSB:0];
                next_cout   = adder_sum[WORD_SIZE];
                next_ovf    = adder_sum[WORD_SIZE];
            end
            CONTROL_SUB: begin
                next_result = adder_sum[MSB:0];
                next_cout   = adder_sum[WORD_SIZE];
                next_ovf    = sub_ovf;
            end
            CONTROL_SLT: begin
                // The sign of the difference is wrong when a-b overflows.
                // XOR with the overflow restores the true signed a<b.
                next_result = {{(WORD_SIZE-1){1'b0}}, adder_sum[MSB] ^ sub_ovf};
            end
            default: next_invalid = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result              <= '0;
            zero                <= 1'b1;
            cout                <= 1'b0;
            err_overflow        <= 1'b0;
            err_invalid_control <= 1'b0;
        end else begin
            result <= next_result;
            zero   <= (next_result == '0);
            cout   <= next_cout;
`ifdef ALU_STICKY_ERR_EN
            err_overflow        <= err_overflow | next_ovf;
            err_invalid_control <= err_invalid_control | next_invalid;
`else
            err_overflow        <= next_ovf;
            err_invalid_control <= next_invalid;
`endif
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Testbench for alu_32. Directed and random operations are driven back to back.
// Each expected output word is queued when its operation is driven, and it is
// compared when the DUT presents the registered result one edge later.
module tb_alu_32;

    localparam int W = 32;
    // Expected word format: {result[31:0], zero, cout, err_overflow, err_invalid_control}
    localparam int EW = W + 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic [3:0]   control;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         err_overflow;
    logic         err_invalid_control;

    alu_32 #(.WORD_SIZE(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .input_a             (input_a),
        .input_b             (input_b),
        .control             (control),
        .result              (result),
        .zero                (zero),
        .cout                (cout),
        .err_overflow        (err_overflow),
        .err_invalid_control (err_invalid_control)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            tests;
    int            fails;
    logic          sticky_ovf;
    logic          sticky_inv;

    function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic c,
                                          input logic o, input logic i);
        return {r, (r == '0), c, o, i};
    endfunction

    // Reference model written with widened arithmetic, independent of the DUT adder.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] ctl);
        logic [W:0]   u;
        logic [W:0]   sx;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         i;
        r = '0; c = 1'b0; o = 1'b0; i = 1'b0;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                u  = {1'b0, a} + {1'b0, b};
                sx = {a[W-1], a} + {b[W-1], b};
                r = u[W-1:0]; c = u[W]; o = sx[W] ^ sx[W-1];
            end
            4'b0011: begin
                u = {1'b0, a} + {1'b0, b};
                r = u[W-1:0]; c = u[W]; o = u[W];
            end
            4'b0110: begin
                u  = {1'b0, a} + {1'b0, ~b} + 1;
                sx = {a[W-1], a} - {b[W-1], b};
                r = u[W-1:0]; c = u[W]; o = sx[W] ^ sx[W-1];
            end
            4'b0111: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: i = 1'b1;
        endcase
        return pk(r, c, o, i);
    endfunction

    // Compares the DUT output with the oldest queued expectation.
    task automatic check_out();
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        string         tag;
        got = {result, zero, cout, err_overflow, err_invalid_control};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got res=%h z=%b c=%b ov=%b inv=%b, exp res=%h z=%b c=%b ov=%b inv=%b",
                   tag, got[EW-1:4], got[3], got[2], got[1], got[0],
                   exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drives one cycle on the falling edge. The output for the previous cycle
    // is checked first, then the expectation for this cycle is queued.
    task automatic step(input string tag, input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] ctl,
                        input logic [EW-1:0] exp_in);
        logic [EW-1:0] e;
        @(negedge clk);
        if (exp_q.size() > 0) check_out();
        rst = r; input_a = a; input_b = b; control = ctl;
        e = exp_in;
        if (r) begin
            e = pk('0, 1'b0, 1'b0, 1'b0);
            sticky_ovf = 1'b0;
            sticky_inv = 1'b0;
        end else begin
`ifdef ALU_STICKY_ERR_EN
            e[1] = e[1] | sticky_ovf;
            e[0] = e[0] | sticky_inv;
            sticky_ovf = e[1];
            sticky_inv = e[0];
`endif
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Pick an opcode, with one of the eight draws going to a random (often invalid) code.
    function automatic logic [3:0] pick_ctl();
        logic [3:0] tbl [0:6];
        int k;
        tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0010; tbl[3] = 4'b0011;
        tbl[4] = 4'b0110; tbl[5] = 4'b0111; tbl[6] = 4'b1100;
        k = $urandom_range(0, 7);
        if (k == 7) return 4'($urandom_range(0, 15));
        return tbl[k];
    endfunction

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_ADDU = 4'b0011, C_SUB = 4'b0110, C_SLT = 4'b0111,
                           C_NOR = 4'b1100;

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   rc;
        tests = 0; fails = 0;
        sticky_ovf = 1'b0; sticky_inv = 1'b0;
        rst = 1'b1; input_a = '0; input_b = '0; control = '0;
        repeat (2) @(posedge clk);

        step("reset_state", 1'b1, 32'h1234_5678, 32'h1, C_ADD, '0);
        step("and_zero", 1'b0, 32'h0000_FF00, 32'h0000_00FF, C_AND, pk(32'h0, 0, 0, 0));
        step("or_ones",  1'b0, 32'hFFFF_FFFF, 32'h0000_000F, C_OR,  pk(32'hFFFF_FFFF, 0, 0, 0));
        step("nor",      1'b0, 32'h1, 32'h1, C_NOR, pk(32'hFFFF_FFFE, 0, 0, 0));
        step("addu_wrap", 1'b0, 32'hFFFF_FFFF, 32'h1, C_ADDU, pk(32'h0, 1, 1, 0));
        step("addu_plain", 1'b0, 32'd1234, 32'd4321, C_ADDU, pk(32'h0000_15B3, 0, 0, 0));
        step("add_posovf", 1'b0, 32'h7FFF_FFFF, 32'h1, C_ADD, pk(32'h8000_0000, 0, 1, 0));
        step("add_negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, C_ADD, pk(32'h0, 1, 1, 0));
        step("add_m1p1",   1'b0, 32'hFFFF_FFFF, 32'h1, C_ADD, pk(32'h0, 1, 0, 0));
        step("sub_neg",    1'b0, 32'd100, 32'd101, C_SUB, pk(32'hFFFF_FFFF, 0, 0, 0));
        step("sub_ovf1",   1'b0, 32'h8000_0000, 32'h1, C_SUB, pk(32'h7FFF_FFFF, 1, 1, 0));
        step("sub_ovf2",   1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, C_SUB, pk(32'h8000_0000, 0, 1, 0));
        step("sub_equal",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, C_SUB, pk(32'h0, 1, 0, 0));
        step("slt_1_2",    1'b0, 32'd1, 32'd2, C_SLT, pk(32'h1, 0, 0, 0));
        step("slt_neg",    1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, C_SLT, pk(32'h1, 0, 0, 0));
        step("slt_0_m1",   1'b0, 32'h0, 32'hFFFF_FFFF, C_SLT, pk(32'h0, 0, 0, 0));
        step("slt_m1_0",   1'b0, 32'hFFFF_FFFF, 32'h0, C_SLT, pk(32'h1, 0, 0, 0));
        step("slt_ovf",    1'b0, 32'h8000_0000, 32'h7FFF_FFFF, C_SLT, pk(32'h1, 0, 0, 0));
        step("invalid_f",  1'b0, 32'hDEAD_BEEF, 32'h1, 4'hF, pk(32'h0, 0, 0, 1));
        step("and_after_inv", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, C_AND, pk(32'hF000_F000, 0, 0, 0));
        step("reset_mid",  1'b1, 32'hFFFF_FFFF, 32'h1, C_ADDU, '0);
        step("or_after_rst", 1'b0, 32'h0, 32'h0, C_OR, pk(32'h0, 0, 0, 0));

        for (int n = 0; n < 60; n++) begin
            ra = $urandom();
            rb = $urandom();
            if (n % 10 == 0) rb = ra;
            rc = pick_ctl();
            step("random", 1'b0, ra, rb, rc, model(ra, rb, rc));
        end

        // One more cycle flushes the last expectation.
        @(negedge clk);
        if (exp_q.size() > 0) check_out();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
